// File: rtl/mask_codec_pkg.sv
// Shared types and sizing for the code-to-mask decoder: index width, mask width,
// frame FSM states and the distinct-bit count type.
package mask_codec_pkg;

  localparam int CODE_W = 3;
  localparam int MASK_W = 1 << CODE_W;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  typedef logic [CODE_W:0] count_t;

endpackage

// File: rtl/onehot_decoder.sv
// Combinational CODE_W-to-MASK_W one-hot decode.
module onehot_decoder #(
  parameter int CODE_W = 3,
  parameter int MASK_W = 1 << CODE_W
) (
  input  logic [CODE_W-1:0] code,
  output logic [MASK_W-1:0] onehot
);

  // Place a single set bit at the indexed position.
  always_comb begin
    onehot = {{(MASK_W-1){1'b0}}, 1'b1} << code;
  end

endmodule

// File: rtl/mask_decoder.sv
// Accumulates a frame of bit indices into a mask, then presents the mask with its
// distinct-bit count and a duplicate flag on a valid/ready output.
module mask_decoder #(
  parameter int CODE_W = mask_codec_pkg::CODE_W,
  parameter int MASK_W = 1 << CODE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MASK_W-1:0] out_mask,
  output logic [CODE_W:0]   out_count,
  output logic              out_dup
);

  import mask_codec_pkg::*;

  state_t            state_r;
  logic [MASK_W-1:0] mask_r;
  logic [CODE_W:0]   count_r;
  logic              dup_r;

  logic              accept_s;
  logic              fresh_s;
  logic [CODE_W-1:0] code_s;
  logic [MASK_W-1:0] onehot_s;
  logic [MASK_W-1:0] base_mask_s;
  logic [CODE_W:0]   base_count_s;
  logic              base_dup_s;
  logic              hit_s;

  assign out_valid = (state_r == HOLD);
  assign in_ready  = !out_valid || out_ready;
  assign accept_s  = in_valid && in_ready;

  // The code is forced to zero when not accepted so an undriven index cannot leak.
  assign code_s = accept_s ? in_code : {CODE_W{1'b0}};

  onehot_decoder #(
    .CODE_W (CODE_W),
    .MASK_W (MASK_W)
  ) u_onehot (
    .code   (code_s),
    .onehot (onehot_s)
  );

  // A beat accepted while holding coincides with the output handshake: start a fresh frame.
  always_comb begin
    case (state_r)
      ACCUM:   fresh_s = 1'b0;
      HOLD:    fresh_s = 1'b1;
      default: fresh_s = 1'b0;
    endcase
  end

  assign base_mask_s  = fresh_s ? {MASK_W{1'b0}} : mask_r;
  assign base_count_s = fresh_s ? {(CODE_W+1){1'b0}} : count_r;
  assign base_dup_s   = fresh_s ? 1'b0 : dup_r;
  assign hit_s        = |(base_mask_s & onehot_s);

  // Frame FSM together with the mask, count and duplicate registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ACCUM;
      mask_r  <= {MASK_W{1'b0}};
      count_r <= {(CODE_W+1){1'b0}};
      dup_r   <= 1'b0;
    end else if (accept_s) begin
      mask_r  <= base_mask_s | onehot_s;
      count_r <= base_count_s + {{CODE_W{1'b0}}, !hit_s};
      dup_r   <= base_dup_s | hit_s;
      state_r <= in_last ? HOLD : ACCUM;
    end else if (out_valid && out_ready) begin
      state_r <= ACCUM;
      mask_r  <= {MASK_W{1'b0}};
      count_r <= {(CODE_W+1){1'b0}};
      dup_r   <= 1'b0;
    end else begin
      state_r <= state_r;
      mask_r  <= mask_r;
      count_r <= count_r;
      dup_r   <= dup_r;
    end
  end

  assign out_mask  = mask_r;
  assign out_count = count_r;
  assign out_dup   = dup_r;

endmodule

// File: tb/tb_mask_decoder.sv
// Self-checking bench for mask_decoder: directed frame table, multi-cycle corner
// sequences, and randomly throttled frames against a set-based reference model.
module tb_mask_decoder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_code;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_mask;
  logic [3:0] out_count;
  logic       out_dup;

  int n_cmp;
  int n_err;

  mask_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mask  (out_mask),
    .out_count (out_count),
    .out_dup   (out_dup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int              n;
    logic [7:0][2:0] codes;
    logic [7:0]      mask;
    logic [3:0]      count;
    logic            dup;
  } vec_t;

  typedef struct {
    logic [2:0] code;
    logic       last;
  } beat_t;

  typedef struct {
    logic [7:0] mask;
    logic [3:0] count;
    logic       dup;
  } frame_t;

  vec_t   vecs[4];
  beat_t  beats[$];
  frame_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [7:0] m, input logic [3:0] c, input logic d);
    check({name, "_valid"}, out_valid, 1'b1);
    check({name, "_mask"},  out_mask,  m);
    check({name, "_count"}, out_count, c);
    check({name, "_dup"},   out_dup,   d);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_code  = 3'd0;
    in_last  = 1'b0;
  endtask

  task automatic drive_beat(input logic [2:0] code, input logic last);
    @(negedge clk);
    in_valid  = 1'b1;
    in_code   = code;
    in_last   = last;
    out_ready = 1'b1;
  endtask

  task automatic run_vec(input int idx);
    for (int i = 0; i < vecs[idx].n; i++) begin
      drive_beat(vecs[idx].codes[i], (i == vecs[idx].n - 1));
    end
    @(negedge clk);
    idle_inputs();
    check_out($sformatf("tbl%0d", idx), vecs[idx].mask, vecs[idx].count, vecs[idx].dup);
  endtask

  initial begin
    int cyc;
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    idle_inputs();

    vecs[0] = '{n: 2, codes: {18'd0, 3'd7, 3'd5}, mask: 8'ha0, count: 4'd2, dup: 1'b0};
    vecs[1] = '{n: 5, codes: {9'd0, 3'd2, 3'd1, 3'd3, 3'd2, 3'd1}, mask: 8'h0e, count: 4'd3, dup: 1'b1};
    vecs[2] = '{n: 1, codes: {21'd0, 3'd0}, mask: 8'h01, count: 4'd1, dup: 1'b0};
    vecs[3] = '{n: 8, codes: {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
                mask: 8'hff, count: 4'd8, dup: 1'b0};

    repeat (3) @(negedge clk);
    check("rst_valid", out_valid, 1'b0);
    check("rst_mask",  out_mask,  8'h00);
    check("rst_count", out_count, 4'd0);
    check("rst_dup",   out_dup,   1'b0);
    check("rst_ready", in_ready,  1'b1);
    rst_n = 1'b1;

    for (int k = 0; k < 4; k++) run_vec(k);

    // Backpressure: hold the frame, then swap in a new single-beat frame on the handshake.
    drive_beat(3'd2, 1'b1);
    @(negedge clk);
    idle_inputs();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", in_ready, 1'b0);
      check_out("bp_hold", 8'h04, 4'd1, 1'b0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_code   = 3'd6;
    in_last   = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1'b1);
    @(negedge clk);
    idle_inputs();
    check_out("bp_fresh", 8'h40, 4'd1, 1'b0);

    // Reset mid-frame discards the partial frame immediately.
    @(negedge clk);
    drive_beat(3'd4, 1'b0);
    drive_beat(3'd3, 1'b0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check("mrst_valid", out_valid, 1'b0);
    check("mrst_mask",  out_mask,  8'h00);
    check("mrst_count", out_count, 4'd0);
    check("mrst_dup",   out_dup,   1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_beat(3'd0, 1'b1);
    @(negedge clk);
    idle_inputs();
    check_out("mrst_after", 8'h01, 4'd1, 1'b0);

    // Random frames: expected result is the set of distinct codes in each frame.
    for (int f = 0; f < 1000; f++) begin
      int     len;
      frame_t fr;
      len      = $urandom_range(1, 10);
      fr.mask  = 8'h00;
      for (int b = 0; b < len; b++) begin
        beat_t bt;
        bt.code = 3'($urandom_range(0, 7));
        bt.last = (b == len - 1);
        beats.push_back(bt);
        fr.mask = fr.mask | (8'h01 << bt.code);
      end
      fr.count = 4'($countones(fr.mask));
      fr.dup   = (len != int'(fr.count));
      exp_q.push_back(fr);
    end

    cyc = 0;
    @(negedge clk);
    while ((beats.size() > 0 || exp_q.size() > 0) && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (beats.size() > 0 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_code  = beats[0].code;
        in_last  = beats[0].last;
      end else begin
        in_valid = 1'b0;
        in_code  = 3'($urandom_range(0, 7));
        in_last  = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (in_ready !== (!out_valid || out_ready)) begin
        check("rnd_in_ready", in_ready, !out_valid || out_ready);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rnd_extra_frame", 1'b1, 1'b0);
        end else begin
          check_out("rnd", exp_q[0].mask, exp_q[0].count, exp_q[0].dup);
          void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) void'(beats.pop_front());
    end
    check("rnd_timeout", (cyc >= 60000), 1'b0);
    check("rnd_pending_frames", exp_q.size(), 0);
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
